// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer.
package calc_pkg;

  typedef enum logic [2:0] {
    ST_ENTER_A  = 3'd0,
    ST_ENTER_OP = 3'd1,
    ST_ENTER_B  = 3'd2,
    ST_COMPUTE  = 3'd3,
    ST_SHOW     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_AND = 2'd3
  } opcode_t;

  localparam logic [7:0] ERR_DISPLAY         = 8'hEE;
  localparam int         DEFAULT_ALU_TIMEOUT = 255;

  // Wrap-around +1/-1 on a 4-bit operand.
  function automatic logic [3:0] step_nibble(input logic [3:0] v, input logic dn);
    return dn ? (v - 4'd1) : (v + 4'd1);
  endfunction

endpackage

// File: rtl/calc_debounce.sv
// Button conditioner: 2-flop synchronizer, debounce counter, one-cycle press pulse.
module calc_debounce
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Synchronize, then accept a new level only after it has differed for the full window.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == LAST) begin
          r_cnt   <= '0;
          r_level <= r_sync2;
          r_press <= r_sync2;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator front end: buttons and rotary edit operands/opcode, drives an
// external ALU, and multiplexes the result onto a two-digit display.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REFRESH_CYCLES  = 256,
  parameter int ALU_TIMEOUT     = DEFAULT_ALU_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       select_in,
  input  logic       restart_in,
  input  logic       rotary_a,
  input  logic       rotary_b,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  output logic       alu_start,
  input  logic       alu_done,
  input  logic [7:0] alu_result,
  input  logic       alu_error,
  output logic [3:0] digit_nibble,
  output logic       digit_sel,
  output logic       led_flag,
  output logic       sync
);

  localparam int TW = $clog2(ALU_TIMEOUT + 1);
  localparam int RW = $clog2(REFRESH_CYCLES + 1);

  logic          w_sel_press;
  logic          w_rst_press;
  logic          w_step;
  logic          w_dn;
  logic          w_timeout;
  logic          w_ref_wrap;
  logic          w_sel_next;
  logic [7:0]    w_display;
  state_t        w_next_state;

  state_t        r_state;
  logic          r_a_s1, r_a_s2, r_a_prev;
  logic          r_b_s1, r_b_s2;
  logic [3:0]    r_alu_a;
  logic [3:0]    r_alu_b;
  logic [1:0]    r_alu_op;
  logic          r_alu_start;
  logic [7:0]    r_result;
  logic          r_err;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_sync;
  logic [RW-1:0] r_ref_cnt;
  logic          r_digit_sel;
  logic [3:0]    r_digit_nibble;
  logic          r_led;

  calc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_select_db (
    .i_clk(clk), .i_reset(reset), .i_btn(select_in), .o_press(w_sel_press)
  );

  calc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_restart_db (
    .i_clk(clk), .i_reset(reset), .i_btn(restart_in), .o_press(w_rst_press)
  );

  // Synchronize the quadrature inputs and keep the previous A for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_s1   <= 1'b0;
      r_a_s2   <= 1'b0;
      r_a_prev <= 1'b0;
      r_b_s1   <= 1'b0;
      r_b_s2   <= 1'b0;
    end else begin
      r_a_s1   <= rotary_a;
      r_a_s2   <= r_a_s1;
      r_a_prev <= r_a_s2;
      r_b_s1   <= rotary_b;
      r_b_s2   <= r_b_s1;
    end
  end

  assign w_step    = r_a_s2 & ~r_a_prev;
  assign w_dn      = r_b_s2;
  assign w_timeout = (r_state == ST_COMPUTE) && (r_tmo_cnt == TW'(ALU_TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ENTER_A;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: restart beats select, select beats everything else.
  always_comb begin
    w_next_state = r_state;
    if (w_rst_press) begin
      w_next_state = ST_ENTER_A;
    end else begin
      case (r_state)
        ST_ENTER_A:  w_next_state = w_sel_press ? ST_ENTER_OP : ST_ENTER_A;
        ST_ENTER_OP: w_next_state = w_sel_press ? ST_ENTER_B : ST_ENTER_OP;
        ST_ENTER_B:  w_next_state = w_sel_press ? ST_COMPUTE : ST_ENTER_B;
        ST_COMPUTE:  w_next_state = (alu_done || w_timeout) ? ST_SHOW : ST_COMPUTE;
        ST_SHOW:     w_next_state = w_sel_press ? ST_ENTER_A : ST_SHOW;
        default:     w_next_state = ST_ENTER_A;
      endcase
    end
  end

  // Operand editing, ALU handshake, result latch and state-change pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_a     <= 4'd0;
      r_alu_b     <= 4'd0;
      r_alu_op    <= 2'd0;
      r_alu_start <= 1'b0;
      r_result    <= 8'h00;
      r_err       <= 1'b0;
      r_tmo_cnt   <= '0;
      r_sync      <= 1'b0;
    end else begin
      r_alu_start <= 1'b0;
      r_sync      <= (w_next_state != r_state) || w_rst_press;
      if (w_rst_press) begin
        r_alu_a   <= 4'd0;
        r_alu_b   <= 4'd0;
        r_alu_op  <= 2'd0;
        r_result  <= 8'h00;
        r_err     <= 1'b0;
        r_tmo_cnt <= '0;
      end else begin
        case (r_state)
          ST_ENTER_A: begin
            if (!w_sel_press && w_step) r_alu_a <= step_nibble(r_alu_a, w_dn);
          end
          ST_ENTER_OP: begin
            if (!w_sel_press && w_step) r_alu_op <= w_dn ? (r_alu_op - 2'd1) : (r_alu_op + 2'd1);
          end
          ST_ENTER_B: begin
            if (w_sel_press) begin
              r_alu_start <= 1'b1;
              r_tmo_cnt   <= '0;
            end else if (w_step) begin
              r_alu_b <= step_nibble(r_alu_b, w_dn);
            end
          end
          ST_COMPUTE: begin
            if (alu_done) begin
              r_result <= alu_result;
              r_err    <= alu_error;
            end else if (w_timeout) begin
              r_err <= 1'b1;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Value shown on the two-digit display for the current state.
  always_comb begin
    w_display = 8'h00;
    case (r_state)
      ST_ENTER_A:  w_display = {4'h0, r_alu_a};
      ST_ENTER_OP: w_display = {6'd0, r_alu_op};
      ST_ENTER_B:  w_display = {4'h0, r_alu_b};
      ST_COMPUTE:  w_display = 8'h00;
      ST_SHOW:     w_display = r_err ? ERR_DISPLAY : r_result;
      default:     w_display = 8'h00;
    endcase
  end

  assign w_ref_wrap = (r_ref_cnt == RW'(REFRESH_CYCLES - 1));
  assign w_sel_next = w_ref_wrap ? ~r_digit_sel : r_digit_sel;

  // Digit multiplexing and error LED; nibble follows the digit select it is paired with.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ref_cnt      <= '0;
      r_digit_sel    <= 1'b0;
      r_digit_nibble <= 4'h0;
      r_led          <= 1'b0;
    end else begin
      r_ref_cnt      <= w_ref_wrap ? '0 : (r_ref_cnt + RW'(1));
      r_digit_sel    <= w_sel_next;
      r_digit_nibble <= w_sel_next ? w_display[7:4] : w_display[3:0];
      r_led          <= (r_state == ST_SHOW) && r_err;
    end
  end

  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_op       = r_alu_op;
  assign alu_start    = r_alu_start;
  assign digit_nibble = r_digit_nibble;
  assign digit_sel    = r_digit_sel;
  assign led_flag     = r_led;
  assign sync         = r_sync;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: vector table of full calculations,
// an ALU responder, and hand-written sequences for the multi-cycle corners.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int DB = 16;
  localparam int RF = 256;
  localparam int TO = 255;

  logic       clk;
  logic       reset;
  logic       select_in, restart_in, rotary_a, rotary_b;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic       alu_start, alu_done, alu_error;
  logic [7:0] alu_result;
  logic [3:0] digit_nibble;
  logic       digit_sel, led_flag, sync;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor / responder bookkeeping
  int         cyc = 0, sync_total = 0, start_total = 0;
  int         start_cyc = 0, last_sync_cyc = 0, countdown = 0;
  logic [9:0] cap_ops = '0;
  int         resp_delay = -1;
  logic [7:0] resp_result = 8'h00;
  logic       resp_err = 1'b0;

  logic [9:0] exp_q[$];

  typedef struct {
    logic [3:0] a;
    opcode_t    op;
    logic [3:0] b;
    logic [7:0] res;
    logic       err;
    int         delay;
    logic [7:0] disp;
    logic       led;
  } vec_t;
  vec_t vecs[6];

  calc_sequencer #(.DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RF), .ALU_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .select_in(select_in), .restart_in(restart_in),
    .rotary_a(rotary_a), .rotary_b(rotary_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
    .alu_result(alu_result), .alu_error(alu_error), .digit_nibble(digit_nibble),
    .digit_sel(digit_sel), .led_flag(led_flag), .sync(sync)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observe sync/start on the falling edge and play the ALU role.
  initial begin
    alu_done = 1'b0; alu_result = 8'h00; alu_error = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      alu_done = 1'b0;
      if (countdown == 1) begin
        alu_done = 1'b1; alu_result = resp_result; alu_error = resp_err;
      end
      if (countdown > 0) countdown--;
      if (sync) begin sync_total++; last_sync_cyc = cyc; end
      if (alu_start) begin
        start_total++; start_cyc = cyc;
        cap_ops = {alu_a, alu_b, alu_op};
        countdown = resp_delay;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic sel, input logic rst);
    select_in = sel; restart_in = rst;
    cycles(DB + 6);
    select_in = 1'b0; restart_in = 1'b0;
    cycles(DB + 6);
  endtask

  task automatic step(input logic dn);
    rotary_b = dn; cycles(2);
    rotary_a = 1'b1; cycles(4);
    rotary_a = 1'b0; cycles(4);
  endtask

  task automatic dial(input int target, input int modulus);
    if (target <= modulus / 2) repeat (target) step(1'b0);
    else repeat (modulus - target) step(1'b1);
  endtask

  // Returns cycles until digit_sel changes, or -1 if it never does within the budget.
  task automatic wait_toggle(output int n);
    logic prev;
    prev = digit_sel;
    n = -1;
    for (int k = 0; k < RF + 20; k++) begin
      @(negedge clk);
      if (digit_sel !== prev) begin n = k + 1; break; end
    end
  endtask

  initial begin
    int s0, t0, per, exp_lat;
    logic [9:0] exp_ops;
    logic [7:0] d;

    vecs[0] = '{4'd5,  OP_ADD, 4'd7,  8'h0C, 1'b0,  4, 8'h0C, 1'b0};
    vecs[1] = '{4'd3,  OP_SUB, 4'd1,  8'h02, 1'b0,  2, 8'h02, 1'b0};
    vecs[2] = '{4'd15, OP_MUL, 4'd4,  8'h3C, 1'b0,  1, 8'h3C, 1'b0};
    vecs[3] = '{4'd9,  OP_AND, 4'd12, 8'h08, 1'b0,  6, 8'h08, 1'b0};
    vecs[4] = '{4'd2,  OP_ADD, 4'd2,  8'h00, 1'b0, -1, 8'hEE, 1'b1};
    vecs[5] = '{4'd1,  OP_SUB, 4'd2,  8'hFF, 1'b1,  3, 8'hEE, 1'b1};

    reset = 1'b1; select_in = 1'b0; restart_in = 1'b0; rotary_a = 1'b0; rotary_b = 1'b0;
    cycles(5);
    chk("rst_ops",    32'({alu_a, alu_b, alu_op}), 0);
    chk("rst_start",  32'(alu_start), 0);
    chk("rst_outs",   32'({digit_sel, digit_nibble, led_flag, sync}), 0);
    chk("rst_state",  32'(dut.r_state), 32'(ST_ENTER_A));
    reset = 1'b0;
    cycles(3);

    // Three +steps then select
    s0 = sync_total;
    repeat (3) step(1'b0);
    chk("three_steps", 32'(alu_a), 3);
    press(1'b1, 1'b0);
    chk("to_enter_op", 32'(dut.r_state), 32'(ST_ENTER_OP));
    chk("one_sync",    sync_total - s0, 1);

    // Opcode wrap both ways
    step(1'b1);
    chk("op_wrap_down", 32'(alu_op), 3);
    step(1'b0);
    chk("op_wrap_up", 32'(alu_op), 0);

    // Operand A wrap below zero, then restart from ENTER_A still pulses sync
    press(1'b0, 1'b1);
    step(1'b1);
    chk("a_wrap_down", 32'(alu_a), 15);
    s0 = sync_total;
    press(1'b0, 1'b1);
    chk("restart_same_state_sync", sync_total - s0, 1);
    chk("restart_clear_a", 32'(alu_a), 0);

    for (int i = 0; i < 6; i++) begin
      press(1'b0, 1'b1);
      chk("restart_clears", 32'({alu_a, alu_b, alu_op}), 0);
      dial(int'(vecs[i].a), 16);
      chk("enter_a", 32'(alu_a), 32'(vecs[i].a));
      press(1'b1, 1'b0);
      dial(int'(vecs[i].op), 4);
      chk("enter_op", 32'(alu_op), 32'(vecs[i].op));
      press(1'b1, 1'b0);
      dial(int'(vecs[i].b), 16);
      chk("enter_b", 32'(alu_b), 32'(vecs[i].b));
      resp_delay = vecs[i].delay; resp_result = vecs[i].res; resp_err = vecs[i].err;
      exp_q.push_back({vecs[i].a, vecs[i].b, 2'(vecs[i].op)});
      s0 = start_total;
      press(1'b1, 1'b0);
      if (vecs[i].delay < 0) begin
        step(1'b0);
        chk("b_frozen_in_compute", 32'(alu_b), 32'(vecs[i].b));
      end
      cycles(300);
      chk("start_one_cycle", start_total - s0, 1);
      exp_ops = exp_q.pop_front();
      chk("operands", 32'(cap_ops), 32'(exp_ops));
      exp_lat = (vecs[i].delay >= 0) ? vecs[i].delay + 1 : TO;
      chk("show_latency", last_sync_cyc - start_cyc, exp_lat);
      chk("show_state", 32'(dut.r_state), 32'(ST_SHOW));
      chk("led_flag", 32'(led_flag), 32'(vecs[i].led));
      d = vecs[i].disp;
      chk("nibble", 32'(digit_nibble), 32'(digit_sel ? d[7:4] : d[3:0]));
      if (i == 0) begin
        wait_toggle(t0);
        chk("sel_toggle_seen", (t0 > 0) ? 1 : 0, 1);
        chk("nibble_after_toggle", 32'(digit_nibble), 32'(digit_sel ? d[7:4] : d[3:0]));
        wait_toggle(per);
        chk("refresh_period", per, RF);
        chk("nibble_other_digit", 32'(digit_nibble), 32'(digit_sel ? d[7:4] : d[3:0]));
      end
      press(1'b1, 1'b0);
      chk("back_to_a", 32'(dut.r_state), 32'(ST_ENTER_A));
      chk("retained", 32'({alu_a, alu_b, alu_op}), 32'({vecs[i].a, vecs[i].b, 2'(vecs[i].op)}));
    end

    // Short select glitch must not be accepted
    press(1'b0, 1'b1);
    s0 = sync_total;
    select_in = 1'b1; cycles(DB - 6);
    select_in = 1'b0; cycles(DB + 6);
    chk("glitch_state", 32'(dut.r_state), 32'(ST_ENTER_A));
    chk("glitch_no_sync", sync_total - s0, 0);

    // Restart and select together in ENTER_B
    dial(4, 16);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    dial(5, 16);
    s0 = start_total;
    press(1'b1, 1'b1);
    chk("rs_state", 32'(dut.r_state), 32'(ST_ENTER_A));
    chk("rs_fields", 32'({alu_a, alu_b, alu_op}), 0);
    chk("rs_no_start", start_total - s0, 0);

    // Reset in the middle of COMPUTE, with alu_done arriving afterwards
    dial(1, 16);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    dial(1, 16);
    resp_delay = 30; resp_result = 8'h02; resp_err = 1'b0;
    exp_q.push_back({4'd1, 4'd1, 2'd0});
    s0 = start_total;
    press(1'b1, 1'b0);
    reset = 1'b1; cycles(3); reset = 1'b0;
    t0 = sync_total;
    cycles(60);
    chk("mid_start_once", start_total - s0, 1);
    exp_ops = exp_q.pop_front();
    chk("mid_operands", 32'(cap_ops), 32'(exp_ops));
    chk("mid_state", 32'(dut.r_state), 32'(ST_ENTER_A));
    chk("mid_no_sync", sync_total - t0, 0);
    chk("mid_start_low", 32'(alu_start), 0);
    chk("mid_display", 32'({digit_nibble, led_flag}), 0);
    chk("mid_fields", 32'({alu_a, alu_b, alu_op}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
